seq_magnitude_comparator: RTL and testbench

Parametrised multi-cycle magnitude comparator for the Huffman encoder's frequency-sort and tree-build stages. It compares two unsigned operands MSB-first, DIGIT_W bits per cycle, with a runtime-selectable active width, and stops early on the first differing digit. A start/ready/done handshake lets a sorter FSM issue back-to-back compares. Results are held until the next accepted start.

---
 rtl/seq_magnitude_comparator_if.sv | 36 +++
 rtl/seq_magnitude_comparator.sv | 106 ++++++++++
 tb/tb_seq_magnitude_comparator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle between a sorter FSM (master) and seq_magnitude_comparator (slave).
// The is_signed request bit exists only when SEQ_CMP_SIGNED_EN is defined.
interface seq_magnitude_comparator_if #(
   parameter int DATA_W = 9
);
   localparam int NB_W = $clog2(DATA_W + 1);

   logic              compare_start;
   logic [NB_W-1:0]   num_of_bits;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
`ifdef SEQ_CMP_SIGNED_EN
   logic              is_signed;
`endif
   logic              compare_ready;
   logic              is_compare_done;
   logic              is_equal;
   logic              is_greater;
   logic              is_less_than;

   modport master (
`ifdef SEQ_CMP_SIGNED_EN
      output is_signed,
`endif
      output compare_start, num_of_bits, A, B,
      input  compare_ready, is_compare_done, is_equal, is_greater, is_less_than
   );

   modport slave (
`ifdef SEQ_CMP_SIGNED_EN
      input  is_signed,
`endif
      input  compare_start, num_of_bits, A, B,
      output compare_ready, is_compare_done, is_equal, is_greater, is_less_than
   );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// MSB-first multi-cycle magnitude comparator, DIGIT_W bits per cycle, with early exit.
// Define SEQ_CMP_SIGNED_EN to add a two's-complement mode (is_signed request bit).
module seq_magnitude_comparator #(
   parameter int DATA_W  = 9,
   parameter int DIGIT_W = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   seq_magnitude_comparator_if.slave bus
);
   localparam int NB_W  = $clog2(DATA_W + 1);
   localparam int NDIG  = (DATA_W + DIGIT_W - 1) / DIGIT_W;
   localparam int PAD_W = NDIG * DIGIT_W;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CMP  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [PAD_W-1:0] r_opA;
   logic [PAD_W-1:0] r_opB;
   logic [IDX_W-1:0] r_idx;
   logic             r_isEqual;
   logic             r_isGreater;
   logic             r_isLess;

   logic [NB_W-1:0]    w_nb;
   logic [DATA_W-1:0]  w_mask;
   logic [DATA_W-1:0]  w_flip;
   logic [DATA_W-1:0]  w_latchA;
   logic [DATA_W-1:0]  w_latchB;
   logic [IDX_W-1:0]   w_startIdx;
   logic [DIGIT_W-1:0] w_digA;
   logic [DIGIT_W-1:0] w_digB;

   assign w_nb = (int'(bus.num_of_bits) > DATA_W) ? NB_W'(DATA_W) : bus.num_of_bits;

   // Inverting the active sign bit turns two's complement into offset binary,
   // so the same unsigned digit walk gives the signed ordering.
   always_comb begin
      w_mask = '0;
      w_flip = '0;
      for (int i = 0; i < DATA_W; i++) begin
         w_mask[i] = (i < int'(w_nb));
`ifdef SEQ_CMP_SIGNED_EN
         w_flip[i] = bus.is_signed && (i == int'(w_nb) - 1);
`endif
      end
   end

   assign w_latchA   = (bus.A & w_mask) ^ w_flip;
   assign w_latchB   = (bus.B & w_mask) ^ w_flip;
   assign w_startIdx = (w_nb == '0) ? '0 : IDX_W'((int'(w_nb) - 1) / DIGIT_W);

   assign w_digA = r_opA[int'(r_idx) * DIGIT_W +: DIGIT_W];
   assign w_digB = r_opB[int'(r_idx) * DIGIT_W +: DIGIT_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_opA       <= '0;
         r_opB       <= '0;
         r_idx       <= '0;
         r_isEqual   <= 1'b0;
         r_isGreater <= 1'b0;
         r_isLess    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.compare_start) begin
                  r_opA       <= PAD_W'(w_latchA);
                  r_opB       <= PAD_W'(w_latchB);
                  r_idx       <= w_startIdx;
                  r_isEqual   <= 1'b0;
                  r_isGreater <= 1'b0;
                  r_isLess    <= 1'b0;
                  r_state     <= S_CMP;
               end
            end
            S_CMP: begin
               if (w_digA > w_digB) begin
                  r_isGreater <= 1'b1;
                  r_state     <= S_DONE;
               end else if (w_digA < w_digB) begin
                  r_isLess <= 1'b1;
                  r_state  <= S_DONE;
               end else if (r_idx == '0) begin
                  r_isEqual <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.compare_ready   = (r_state == S_IDLE);
   assign bus.is_compare_done = (r_state == S_DONE);
   assign bus.is_equal        = r_isEqual;
   assign bus.is_greater      = r_isGreater;
   assign bus.is_less_than    = r_isLess;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench: a 1-bit-digit and a 4-bit-digit comparator run the same requests
// side by side and are checked against an integer-arithmetic reference model.
module tb_seq_magnitude_comparator;
   logic clk;
   logic reset;

   int nAssert = 0;
   int nFail   = 0;
   int lat1;
   int lat4;

   seq_magnitude_comparator_if #(.DATA_W(9)) bus1 ();
   seq_magnitude_comparator_if #(.DATA_W(9)) bus4 ();

   seq_magnitude_comparator #(.DATA_W(9), .DIGIT_W(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   seq_magnitude_comparator #(.DATA_W(9), .DIGIT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Result code {equal, greater, less} derived from plain integer comparison.
   function automatic void refModel(input int a, input int b, input int nbIn, input int sgn,
                                    input int dw, output logic [2:0] res, output int lat);
      int nb, ma, mb, va, vb, ndig, p;
      nb   = (nbIn > 9) ? 9 : nbIn;
      ma   = a % (1 << nb);
      mb   = b % (1 << nb);
      va   = ma;
      vb   = mb;
      ndig = (nb == 0) ? 1 : (nb + dw - 1) / dw;
      if (sgn != 0 && nb >= 1) begin
         if (ma >= (1 << (nb - 1))) va = ma - (1 << nb);
         if (mb >= (1 << (nb - 1))) vb = mb - (1 << nb);
      end
      res = (va == vb) ? 3'b100 : ((va > vb) ? 3'b010 : 3'b001);
      if (ma == mb) lat = ndig + 1;
      else begin
         p = 0;
         for (int i = 0; i < 9; i++) if (((ma ^ mb) >> i) % 2 == 1) p = i;
         lat = ndig - p / dw + 1;
      end
   endfunction

   task automatic driveBoth(input int a, input int b, input int nb, input int sgn, input logic start);
      bus1.A = 9'(a);  bus4.A = 9'(a);
      bus1.B = 9'(b);  bus4.B = 9'(b);
      bus1.num_of_bits = 4'(nb);  bus4.num_of_bits = 4'(nb);
      bus1.compare_start = start; bus4.compare_start = start;
`ifdef SEQ_CMP_SIGNED_EN
      bus1.is_signed = (sgn != 0); bus4.is_signed = (sgn != 0);
`else
      if (sgn != 0) $display("[TB] signed request issued without signed support");
`endif
   endtask

   // Called at a falling edge; the start is accepted at the next rising edge (cycle 0).
   task automatic applyStimulus(input int a, input int b, input int nb, input int sgn, input int glitch);
      bit got1, got4;
      int cyc;
      got1 = 0; got4 = 0; lat1 = 0; lat4 = 0;
      driveBoth(a, b, nb, sgn, 1'b1);
      @(posedge clk); @(negedge clk);
      cyc = 1;
      checkVal("busyAtCycle1_d1", {bus1.compare_ready, bus1.is_equal, bus1.is_greater, bus1.is_less_than}, 4'b0000);
      checkVal("busyAtCycle1_d4", {bus4.compare_ready, bus4.is_equal, bus4.is_greater, bus4.is_less_than}, 4'b0000);
      while (!(got1 && got4) && cyc <= 40) begin
         if (cyc == glitch) driveBoth(~a & 511, ~b & 511, 15 - nb, 1 - sgn, 1'b1);
         else begin bus1.compare_start = 1'b0; bus4.compare_start = 1'b0; end
         if (bus1.is_compare_done && !got1) begin got1 = 1; lat1 = cyc; end
         if (bus4.is_compare_done && !got4) begin got4 = 1; lat4 = cyc; end
         if (!(got1 && got4)) begin
            @(posedge clk); @(negedge clk);
            cyc++;
         end
      end
      bus1.compare_start = 1'b0; bus4.compare_start = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [2:0] expRes, input int expLat1, input int expLat4);
      checkVal({tag, "_lat_d1"}, lat1, expLat1);
      checkVal({tag, "_lat_d4"}, lat4, expLat4);
      checkVal({tag, "_flags_d1"}, {bus1.is_equal, bus1.is_greater, bus1.is_less_than}, expRes);
      checkVal({tag, "_flags_d4"}, {bus4.is_equal, bus4.is_greater, bus4.is_less_than}, expRes);
      @(posedge clk); @(negedge clk);
      checkVal({tag, "_idle_d1"}, {bus1.compare_ready, bus1.is_compare_done}, 2'b10);
      checkVal({tag, "_idle_d4"}, {bus4.compare_ready, bus4.is_compare_done}, 2'b10);
   endtask

   initial begin
      logic [2:0] res;
      int a, b, nb, sgn, mode, e1, e4;
      bit sawDone;

      reset = 1'b0;
      driveBoth(0, 0, 0, 0, 1'b0);
      repeat (2) @(negedge clk);
      checkVal("inReset_d1", {bus1.compare_ready, bus1.is_compare_done, bus1.is_equal, bus1.is_greater, bus1.is_less_than}, 5'b10000);
      checkVal("inReset_d4", {bus4.compare_ready, bus4.is_compare_done, bus4.is_equal, bus4.is_greater, bus4.is_less_than}, 5'b10000);
      reset = 1'b1;
      @(negedge clk);
      checkVal("afterReset_d1", {bus1.compare_ready, bus1.is_compare_done, bus1.is_equal, bus1.is_greater, bus1.is_less_than}, 5'b10000);

      applyStimulus(9'h100, 9'h0FF, 9, 0, 0);
      checkOutput("earlyGt", 3'b010, 2, 2);
      applyStimulus(9'h0FF, 9'h100, 9, 0, 0);
      checkOutput("earlyLt", 3'b001, 2, 2);
      applyStimulus(9'h1A5, 9'h1A5, 9, 0, 3);
      checkOutput("fullEqGlitch", 3'b100, 10, 4);
      applyStimulus(9'h1FF, 9'h000, 0, 0, 0);
      checkOutput("nbZero", 3'b100, 2, 2);
      applyStimulus(9'h1F3, 9'h003, 4, 0, 0);
      checkOutput("masked", 3'b100, 5, 2);
      applyStimulus(9'h002, 9'h001, 15, 0, 0);
      checkOutput("clamped", 3'b010, 9, 4);
      applyStimulus(9'h123, 9'h124, 9, 0, 0);
      checkOutput("digitLt", 3'b001, 8, 4);
`ifdef SEQ_CMP_SIGNED_EN
      applyStimulus(4'hF, 4'h1, 4, 1, 0);
      checkOutput("signedLt", 3'b001, 2, 2);
      applyStimulus(4'hF, 4'h1, 4, 0, 0);
      checkOutput("unsignedGt", 3'b010, 2, 2);
`endif

      for (int n = 0; n < 30; n++) begin
         a    = int'($urandom_range(0, 511));
         mode = int'($urandom_range(0, 2));
         b    = (mode == 0) ? a : ((mode == 1) ? (a ^ (1 << $urandom_range(0, 8))) : int'($urandom_range(0, 511)));
         nb   = int'($urandom_range(0, 15));
`ifdef SEQ_CMP_SIGNED_EN
         sgn  = int'($urandom_range(0, 1));
`else
         sgn  = 0;
`endif
         refModel(a, b, nb, sgn, 1, res, e1);
         refModel(a, b, nb, sgn, 4, res, e4);
         applyStimulus(a, b, nb, sgn, 0);
         checkOutput($sformatf("rand%0d", n), res, e1, e4);
      end

      driveBoth(9'h100, 9'h100, 9, 0, 1'b1);
      @(posedge clk); @(negedge clk);
      driveBoth(9'h100, 9'h100, 9, 0, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      checkVal("midReset_d1", {bus1.compare_ready, bus1.is_compare_done, bus1.is_equal, bus1.is_greater, bus1.is_less_than}, 5'b10000);
      checkVal("midReset_d4", {bus4.compare_ready, bus4.is_compare_done, bus4.is_equal, bus4.is_greater, bus4.is_less_than}, 5'b10000);
      @(negedge clk);
      reset = 1'b1;
      sawDone = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus1.is_compare_done || bus4.is_compare_done) sawDone = 1;
      end
      checkVal("noDoneAfterReset", sawDone, 1'b0);
      checkVal("readyAfterReset", {bus1.compare_ready, bus4.compare_ready}, 2'b11);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end
endmodule
